// File: rtl/count_seq_ctrl_if.sv
// Job command channel between a host and count_seq_ctrl.
// Latency: n/a (wires only). Backpressure: the host holds cmd_valid and the job fields until cmd_ready=1.
// Signals: cmd_valid/cmd_ready handshake; cmd_start, cmd_end (W bits); cmd_dir (1=down); cmd_reload.
interface count_seq_ctrl_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_start;
    logic [W-1:0] cmd_end;
    logic         cmd_dir;
    logic         cmd_reload;

    // Host side: issues jobs.
    modport master (
        output cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_reload,
        input  cmd_ready
    );

    // Sequencer side: accepts jobs.
    modport slave (
        input  cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_reload,
        output cmd_ready
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Count-job sequencer: loads a start value, steps once per tick until the end value, pulses done.
// Latency: count loads the edge after acceptance; done is registered, high the cycle after the terminal tick.
// Backpressure: cmd_ready is high only in IDLE; a job offered during RUN waits until the block returns to IDLE.
// Ports: clk, r (async active-high reset), cmd (job channel, slave side), tick (count enable),
//        stop (abort), count/count_bar (registered count and its complement), busy (RUN), done (pulse).
module count_seq_ctrl #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             r,
    count_seq_ctrl_if.slave  cmd,
    input  logic             tick,
    input  logic             stop,
    output logic [W-1:0]     count,
    output logic [W-1:0]     count_bar,
    output logic             busy,
    output logic             done
);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] start_q, start_d;
    logic [W-1:0] end_q,   end_d;
    logic         dir_q,    dir_d;
    logic         reload_q, reload_d;
    logic         done_q,   done_d;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q  <= IDLE;
            count_q  <= '0;
            start_q  <= '0;
            end_q    <= '0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            start_q  <= start_d;
            end_q    <= end_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        start_d  = start_q;
        end_d    = end_q;
        dir_d    = dir_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // tick and stop have no effect here.
                if (cmd.cmd_valid) begin
                    start_d  = cmd.cmd_start;
                    end_d    = cmd.cmd_end;
                    dir_d    = cmd.cmd_dir;
                    reload_d = cmd.cmd_reload;
                    count_d  = cmd.cmd_start;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort: keep the count where it is, no completion pulse.
                    state_d = IDLE;
                end else if (tick) begin
                    // Terminal check uses the count before this step, so
                    // start==end finishes on the first tick with no change.
                    if (count_q == end_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            count_d = start_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (dir_q) begin
                        count_d = count_q - ONE;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count         = count_q;
    assign count_bar     = ~count_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign cmd.cmd_ready = (state_q == IDLE);
endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;
    logic       clk;
    logic       r;
    logic       tick;
    logic       stop;
    logic [3:0] count;
    logic [3:0] count_bar;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    count_seq_ctrl_if #(.W(4)) cif ();

    count_seq_ctrl #(.W(4)) dut (
        .clk       (clk),
        .r         (r),
        .cmd       (cif),
        .tick      (tick),
        .stop      (stop),
        .count     (count),
        .count_bar (count_bar),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] s;
        logic [3:0] e;
        logic       d;
        logic       rl;
        logic       t;
        logic       sp;
        logic [3:0] ec;
        logic       eb;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [3:0] s, input logic [3:0] e,
                       input logic d, input logic rl, input logic t, input logic sp,
                       input logic [3:0] ec, input logic eb, input logic ed, input logic er);
        vec_t x;
        x.v = v; x.s = s; x.e = e; x.d = d; x.rl = rl; x.t = t; x.sp = sp;
        x.ec = ec; x.eb = eb; x.ed = ed; x.er = er;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ec, input logic eb,
                           input logic ed, input logic er);
        logic [3:0] ecb;
        ecb = ~ec;
        chk({tag, ".count"},     int'(count),         int'(ec));
        chk({tag, ".count_bar"}, int'(count_bar),     int'(ecb));
        chk({tag, ".busy"},      int'(busy),          int'(eb));
        chk({tag, ".done"},      int'(done),          int'(ed));
        chk({tag, ".ready"},     int'(cif.cmd_ready), int'(er));
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [3:0] e,
                         input logic d, input logic rl, input logic t, input logic sp);
        cif.cmd_valid  = v;
        cif.cmd_start  = s;
        cif.cmd_end    = e;
        cif.cmd_dir    = d;
        cif.cmd_reload = rl;
        tick           = t;
        stop           = sp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Up job 3..6
        add(1, 3, 6, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   5, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   6, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1,   6, 0, 0, 1);  // tick/stop ignored in IDLE
        // Down job with wrap 1 -> 14
        add(1, 1, 14, 1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  15, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  14, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  14, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,  14, 0, 0, 1);
        // Reload job 2..4, nine ticks
        add(1, 2, 4, 0, 1, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 1);  // stop ends reload job
        // Stall then stop; cmd_valid during RUN must be ignored
        add(1, 5, 9, 0, 0, 0, 0,   5, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0,   7, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1,   7, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 1);
        // start == end
        add(1, 8, 8, 1, 0, 0, 0,   8, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   8, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   8, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 1);
        // Up job with wrap 14 -> 1
        add(1, 14, 1, 0, 0, 0, 0, 14, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  15, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1);

        r = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
        r = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].rl, tbl[i].t, tbl[i].sp);
            step();
            chk_all($sformatf("row%0d", i), tbl[i].ec, tbl[i].eb, tbl[i].ed, tbl[i].er);
        end

        // Back-to-back: second job held during RUN, accepted on the done edge
        drive(1, 3, 4, 0, 0, 0, 0);
        step();
        chk_all("b2b.load1", 4'd3, 1'b1, 1'b0, 1'b0);
        drive(1, 10, 11, 0, 0, 1, 0);
        step();
        chk_all("b2b.step", 4'd4, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("b2b.done1", 4'd4, 1'b0, 1'b1, 1'b1);
        step();
        chk_all("b2b.load2", 4'd10, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        chk_all("b2b.step2", 4'd11, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("b2b.done2", 4'd11, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a cycle while running
        drive(1, 3, 9, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        step();
        chk_all("arst.pre", 4'd5, 1'b1, 1'b0, 1'b0);
        #3;
        r = 1'b1;
        #1;
        chk_all("arst.now", 4'd0, 1'b0, 1'b0, 1'b1);
        #1;
        r = 1'b0;
        step();
        chk_all("arst.after", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
